// File: rtl/eth_pkg.sv
// Shared Ethernet TX definitions: speed encodings and the held-byte record.
package eth_pkg;

    localparam logic [1:0] SPEED_10   = 2'b00;
    localparam logic [1:0] SPEED_100  = 2'b01;
    localparam logic [1:0] SPEED_1000 = 2'b10;

    typedef struct packed {
        logic [7:0] data;
        logic       en;
        logic       er;
    } held_byte_t;

    localparam held_byte_t HOLD_IDLE = '{data: 8'h00, en: 1'b0, er: 1'b0};

    // 2'b11 is not a legal speed code and runs as gigabit
    function automatic logic [1:0] norm_speed(input logic [1:0] s);
        return (s == 2'b11) ? SPEED_1000 : s;
    endfunction

endpackage

// File: rtl/rgmii_txc_gen.sv
// Forwarded-clock pattern and end-of-nibble-period flag for a given phase/speed.
// Latency: combinational.
// Backpressure: none; pure decode.
module rgmii_txc_gen
    import eth_pkg::*;
#(
    parameter int DIV_100 = 5,
    parameter int DIV_10  = 50,
    parameter int PH_W    = 6
) (
    input  logic [PH_W-1:0] phase,
    input  logic [1:0]      speed,
    output logic            txc_d1,
    output logic            txc_d2,
    output logic            period_end
);

    localparam logic [PH_W:0] P100 = (PH_W+1)'(DIV_100);
    localparam logic [PH_W:0] P10  = (PH_W+1)'(DIV_10);

    logic [PH_W:0] period;

    // TXC is high for the first P half-cycles of a P-cycle nibble period;
    // half-cycle index is 2*phase for d1 and 2*phase+1 for d2.
    always_comb begin
        period     = (speed == SPEED_100) ? P100 : P10;
        txc_d1     = 1'b1;
        txc_d2     = 1'b0;
        period_end = 1'b1;
        if (speed == SPEED_100 || speed == SPEED_10) begin
            txc_d1     = {phase, 1'b0} < period;
            txc_d2     = {phase, 1'b1} < period;
            period_end = {1'b0, phase} == (period - (PH_W+1)'(1));
        end
    end

endmodule

// File: rtl/rgmii_tx_ddr_sched.sv
// Schedules GMII bytes onto RGMII DDR pin pairs at 1000/100/10 Mb/s.
// Latency: 1 cycle from byte acceptance to first output half-pair.
// Backpressure: in_ready paces the MAC, once per byte period; no skid buffer.
module rgmii_tx_ddr_sched
    import eth_pkg::*;
#(
    parameter int DIV_100 = 5,
    parameter int DIV_10  = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] speed,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       in_en,
    input  logic       in_er,
    output logic       in_ready,
    output logic [3:0] txd_d1,
    output logic [3:0] txd_d2,
    output logic       ctl_d1,
    output logic       ctl_d2,
    output logic       txc_d1,
    output logic       txc_d2,
    output logic       underrun
);

    localparam int PH_W = $clog2((DIV_10 > DIV_100) ? DIV_10 : DIV_100);

    held_byte_t      hold_q, hold_n;
    logic [1:0]      speed_q, speed_n;
    logic [PH_W-1:0] phase_q, phase_n;
    logic            nib_q, nib_n;
    logic            period_end_q, period_end_n;
    logic            underrun_n;
    logic            txc_d1_n, txc_d2_n;
    logic            gig_n;

    // Decode runs on the next state so the pin registers line up with it.
    rgmii_txc_gen #(
        .DIV_100 (DIV_100),
        .DIV_10  (DIV_10),
        .PH_W    (PH_W)
    ) u_txc_gen (
        .phase      (phase_n),
        .speed      (speed_n),
        .txc_d1     (txc_d1_n),
        .txc_d2     (txc_d2_n),
        .period_end (period_end_n)
    );

    always_comb begin
        hold_n     = hold_q;
        speed_n    = speed_q;
        phase_n    = phase_q;
        nib_n      = nib_q;
        underrun_n = 1'b0;
        if (in_ready) begin
            hold_n     = in_valid ? held_byte_t'({in_data, in_en, in_er}) : HOLD_IDLE;
            speed_n    = norm_speed(speed);
            phase_n    = '0;
            nib_n      = 1'b0;
            underrun_n = hold_q.en && !in_valid;
        end else if (speed_q != SPEED_1000) begin
            if (period_end_q) begin
                phase_n = '0;
                nib_n   = 1'b1;
            end else begin
                phase_n = phase_q + PH_W'(1);
            end
        end
    end

    assign gig_n = (speed_n == SPEED_1000);

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q       <= HOLD_IDLE;
            speed_q      <= SPEED_1000;
            phase_q      <= '0;
            nib_q        <= 1'b0;
            period_end_q <= 1'b1;
            in_ready     <= 1'b0;
            underrun     <= 1'b0;
            txd_d1       <= 4'h0;
            txd_d2       <= 4'h0;
            ctl_d1       <= 1'b0;
            ctl_d2       <= 1'b0;
            txc_d1       <= 1'b0;
            txc_d2       <= 1'b0;
        end else begin
            hold_q       <= hold_n;
            speed_q      <= speed_n;
            phase_q      <= phase_n;
            nib_q        <= nib_n;
            period_end_q <= period_end_n;
            in_ready     <= period_end_n && (gig_n || nib_n);
            underrun     <= underrun_n;
            txd_d1       <= (gig_n || !nib_n) ? hold_n.data[3:0] : hold_n.data[7:4];
            txd_d2       <= (gig_n ||  nib_n) ? hold_n.data[7:4] : hold_n.data[3:0];
            ctl_d1       <= hold_n.en;
            ctl_d2       <= hold_n.en ^ hold_n.er;
            txc_d1       <= txc_d1_n;
            txc_d2       <= txc_d2_n;
        end
    end

endmodule

// File: tb/tb_rgmii_tx_ddr_sched.sv
// Bench for rgmii_tx_ddr_sched: random and directed bytes at all speeds,
// compared cycle by cycle against a byte-level waveform model.
module tb_rgmii_tx_ddr_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] speed;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_en;
    logic       in_er;
    logic       in_ready;
    logic [3:0] txd_d1, txd_d2;
    logic       ctl_d1, ctl_d2, txc_d1, txc_d2;
    logic       underrun;

    always #4 clk = ~clk;

    rgmii_tx_ddr_sched #(.DIV_100(5), .DIV_10(50)) dut (
        .clk      (clk),
        .rst      (rst),
        .speed    (speed),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_en    (in_en),
        .in_er    (in_er),
        .in_ready (in_ready),
        .txd_d1   (txd_d1),
        .txd_d2   (txd_d2),
        .ctl_d1   (ctl_d1),
        .ctl_d2   (ctl_d2),
        .txc_d1   (txc_d1),
        .txc_d2   (txc_d2),
        .underrun (underrun)
    );

    // {txd_d1, txd_d2, ctl_d1, ctl_d2, txc_d1, txc_d2, in_ready, underrun}
    logic [13:0] obs;
    assign obs = {txd_d1, txd_d2, ctl_d1, ctl_d2, txc_d1, txc_d2, in_ready, underrun};

    int n_checks = 0;
    int n_fail   = 0;

    // model state: the byte currently on the wire and what preceded it
    logic [7:0] exp_d;
    logic       exp_en, exp_er, exp_ur, prev_en;
    logic [1:0] exp_spd;

    function automatic int blen();
        if (exp_spd == 2'b01) return 10;
        if (exp_spd == 2'b00) return 100;
        return 1;
    endfunction

    // Expected pins for cycle k of the current byte. A 10/100 byte is two
    // nibble periods of p cycles; TXC is high for the first p of the 2p
    // half-cycles in each nibble period.
    function automatic logic [13:0] model(input int k);
        int         p, c;
        logic [3:0] nib;
        logic       c1, c2;
        if (exp_spd == 2'b10)
            return {exp_d[3:0], exp_d[7:4], exp_en, exp_en ^ exp_er, 1'b1, 1'b0, 1'b1, exp_ur};
        p   = (exp_spd == 2'b01) ? 5 : 50;
        c   = k % p;
        nib = (k < p) ? exp_d[3:0] : exp_d[7:4];
        c1  = (2 * c) < p;
        c2  = (2 * c + 1) < p;
        return {nib, nib, exp_en, exp_en ^ exp_er, c1, c2, (k == 2 * p - 1), (k == 0) && exp_ur};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a byte at a boundary and advances to its first output cycle.
    task automatic drive(input logic v, input logic [7:0] d, input logic en,
                         input logic er, input logic [1:0] spd);
        in_valid = v;
        in_data  = d;
        in_en    = en;
        in_er    = er;
        speed    = spd;
        exp_d    = v ? d : 8'h00;
        exp_en   = v & en;
        exp_er   = v & er;
        exp_spd  = (spd == 2'b11) ? 2'b10 : spd;
        exp_ur   = prev_en & ~v;
        prev_en  = exp_en;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; speed = 2'b10; in_valid = 1'b1; in_data = 8'hFF; in_en = 1'b1; in_er = 1'b1;
        prev_en = 1'b0;
        step();
        step();
        n_checks++;
        if (obs !== 14'h0) begin
            n_fail++; $display("FAIL reset_state got %h exp %h", obs, 14'h0);
        end
        rst = 1'b0; in_valid = 1'b0;
        step();
        n_checks++;
        if (obs !== 14'b0000_0000_0_0_1_0_1_0) begin
            n_fail++; $display("FAIL reset_release got %h exp %h", obs, 14'b0000_0000_0_0_1_0_1_0);
        end
    endtask

    task automatic test_gigabit();
        logic [7:0] dd[2];
        logic       ee[2];
        dd[0] = 8'hA5; ee[0] = 1'b0;
        dd[1] = 8'h3C; ee[1] = 1'b1;
        for (int b = 0; b < 2; b++) begin
            drive(1'b1, dd[b], 1'b1, ee[b], 2'b10);
            n_checks++;
            if (obs !== model(0)) begin
                n_fail++; $display("FAIL gig_directed byte=%0d got %h exp %h", b, obs, model(0));
            end
        end
        for (int b = 0; b < 24; b++) begin
            drive(($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 1) ? 2'b11 : 2'b10);
            n_checks++;
            if (obs !== model(0)) begin
                n_fail++; $display("FAIL gig_random byte=%0d got %h exp %h", b, obs, model(0));
            end
        end
    endtask

    task automatic test_100m();
        for (int b = 0; b < 4; b++) begin
            if (b == 0) drive(1'b1, 8'h5A, 1'b1, 1'b0, 2'b01);
            else        drive(1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 2'b01);
            for (int k = 0; k < blen(); k++) begin
                n_checks++;
                if (obs !== model(k)) begin
                    n_fail++; $display("FAIL m100 byte=%0d k=%0d got %h exp %h", b, k, obs, model(k));
                end
                if (k < blen() - 1) step();
            end
        end
    endtask

    task automatic test_10m();
        for (int b = 0; b < 2; b++) begin
            if (b == 0) drive(1'b1, 8'hF0, 1'b1, 1'b0, 2'b00);
            else        drive(1'b1, 8'($urandom), 1'b1, 1'($urandom), 2'b00);
            for (int k = 0; k < blen(); k++) begin
                n_checks++;
                if (obs !== model(k)) begin
                    n_fail++; $display("FAIL m10 byte=%0d k=%0d got %h exp %h", b, k, obs, model(k));
                end
                if (k < blen() - 1) step();
            end
        end
    endtask

    task automatic test_underrun();
        // en byte, gap (pulse), gap (no pulse), non-en byte, gap (no pulse), en byte at 100M, gap
        logic       vv[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic       ee[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [1:0] ss[7] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01};
        for (int b = 0; b < 7; b++) begin
            drive(vv[b], 8'($urandom), ee[b], 1'b0, ss[b]);
            for (int k = 0; k < blen(); k++) begin
                n_checks++;
                if (obs !== model(k)) begin
                    n_fail++; $display("FAIL underrun byte=%0d k=%0d got %h exp %h", b, k, obs, model(k));
                end
                if (k < blen() - 1) step();
            end
        end
    endtask

    task automatic test_speed_switch();
        logic [1:0] ss[6] = '{2'b10, 2'b01, 2'b01, 2'b00, 2'b10, 2'b01};
        int glitch;
        for (int b = 0; b < 6; b++) begin
            drive(1'b1, 8'($urandom), 1'b1, 1'($urandom), ss[b]);
            glitch = $urandom_range(0, blen() - 1);
            for (int k = 0; k < blen(); k++) begin
                n_checks++;
                if (obs !== model(k)) begin
                    n_fail++; $display("FAIL speed_switch byte=%0d k=%0d got %h exp %h", b, k, obs, model(k));
                end
                if (k == glitch) speed = 2'($urandom);
                if (k < blen() - 1) step();
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 8'($urandom), 1'b1, 1'b0, 2'b00);
        for (int k = 0; k < 20; k++) step();
        rst = 1'b1;
        step();
        n_checks++;
        if (obs !== 14'h0) begin
            n_fail++; $display("FAIL reset_mid got %h exp %h", obs, 14'h0);
        end
        rst = 1'b0;
        prev_en = 1'b0;
        step();
        n_checks++;
        if (obs !== 14'b0000_0000_0_0_1_0_1_0) begin
            n_fail++; $display("FAIL reset_mid_release got %h exp %h", obs, 14'b0000_0000_0_0_1_0_1_0);
        end
        drive(1'b1, 8'($urandom), 1'b1, 1'b0, 2'b00);
        for (int k = 0; k < blen(); k++) begin
            n_checks++;
            if (obs !== model(k)) begin
                n_fail++; $display("FAIL reset_mid_resample k=%0d got %h exp %h", k, obs, model(k));
            end
            if (k < blen() - 1) step();
        end
    endtask

    initial begin
        test_reset();
        test_gigabit();
        test_100m();
        test_10m();
        test_underrun();
        test_speed_switch();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rgmii_tx_ddr_sched.md
Name: rgmii_tx_ddr_sched

Overview:
- Schedules one GMII-style byte stream onto the RGMII TX pins through per-pin output-DDR cells: 4 data (TXD), 1 control (TX_CTL) and 1 forwarded clock (TXC).
- Every output is a (d1, d2) pair: d1 is the rising-edge half, d2 the falling-edge half.
- Handles 1000/100/10 Mb/s: nibble splitting, nibble hold time, forwarded-clock pattern and byte pacing.
- Sits between the TX MAC and the per-pin DDR output cells in the Ethernet PHY interface.

Parameters:
- DIV_100, 5, clk cycles per nibble period at 100M (125 MHz / 25 MHz); must be odd and at least 3.
- DIV_10, 50, clk cycles per nibble period at 10M; must be even and at least 2.

Ports:
- clk, in, 1, 125 MHz TX clock.
- rst, in, 1, synchronous, active-high reset.
- speed, in, 2, 2'b10 = 1000, 2'b01 = 100, 2'b00 = 10; 2'b11 is treated as 1000.
- in_valid, in, 1, byte is present.
- in_data, in, 8, byte.
- in_en, in, 1, GMII TX_EN for this byte.
- in_er, in, 1, GMII TX_ER for this byte.
- in_ready, out, 1, byte accepted this cycle if in_valid=1.
- txd_d1, out, 4, TXD rising half.
- txd_d2, out, 4, TXD falling half.
- ctl_d1, out, 1, TX_CTL rising half.
- ctl_d2, out, 1, TX_CTL falling half.
- txc_d1, out, 1, TXC rising half.
- txc_d2, out, 1, TXC falling half.
- underrun, out, 1, one-cycle pulse on a mid-frame underrun.

Behaviour:
- Reset (rst=1 at a clk edge), registers take these values:
  - all outputs = 0, in_ready = 0;
  - phase counter = 0, nibble select = 0;
  - active speed = 1000, hold byte = idle (en=0, er=0, data=0).
- First in_ready assertion is the cycle after rst deasserts.
- Reset mid-byte: the byte is abandoned, no underrun pulse.
- Byte boundary = cycle where in_ready=1.
  - Gigabit: every cycle.
  - 100M: once per 2*DIV_100 cycles.
  - 10M: once per 2*DIV_10 cycles.
  - in_ready is registered, derived from the phase counter, independent of in_valid.
- Acceptance:
  - At a boundary, in_valid=1: the hold register loads {in_data, in_en, in_er}.
  - At a boundary, in_valid=0: the hold register loads idle.
  - If the previous held byte had en=1 and in_valid=0 arrives, underrun pulses 1 on the next cycle.
- Speed is sampled only at byte boundaries. It is applied starting with the byte accepted at that boundary; a mid-byte change has no effect until the next boundary.
- Gigabit output (registered, latency 1: byte accepted at cycle N appears on the outputs at N+1):
  - txd_d1 = data[3:0], txd_d2 = data[7:4];
  - ctl_d1 = en, ctl_d2 = en ^ er;
  - txc_d1 = 1, txc_d2 = 0.
- 10/100 output, nibble period P (DIV_100 or DIV_10):
  - Phase counter runs 0..P-1; nibble 0 (data[3:0]) then nibble 1 (data[7:4]).
  - txd_d1 = txd_d2 = current nibble for all P cycles.
  - ctl_d1 = en, ctl_d2 = en ^ er.
  - TXC high for the first P half-cycles of the nibble period:
    - txc_d1 = 1 for cycles 0..(P-1)/2 when P is odd, 0..P/2-1 when P is even;
    - txc_d2 = 1 for cycles 0..(P-3)/2 when P is odd, 0..P/2-1 when P is even.
  - DIV_100=5 gives (d1,d2) per cycle: 11, 11, 10, 00, 00.
  - DIV_10=50 gives 11 for cycles 0..24 and 00 for cycles 25..49.
  - Latency 1: a byte accepted at cycle N starts phase 0 at N+1.
- Wrap: at phase P-1 of nibble 1, phase and nibble select return to 0; in_ready=1 in that same cycle.
- A speed change at a boundary resets phase and nibble select to 0. The outgoing byte always completes at its own speed.

Decomposition:
- Shared package eth_pkg:
  - SPEED_10 = 2'b00, SPEED_100 = 2'b01, SPEED_1000 = 2'b10;
  - the packed struct for the held byte {data[7:0], en, er}.
- One sub-module, rgmii_txc_gen:
  - inputs: phase counter and active speed;
  - outputs: txc_d1/txc_d2 pattern and a boundary flag.

Test Plan:
- Reset then gigabit, bytes 0xA5 (en=1), 0x3C (en=1, er=1) -> cycle 1: txd_d1=5, txd_d2=A, ctl=11; cycle 2: txd_d1=C, txd_d2=3, ctl_d1=1, ctl_d2=0; txc=10 every cycle; in_ready stays 1.
- 100M, byte 0x5A (en=1) -> TXD=A for 5 cycles then 5 for 5 cycles; txc (d1,d2) = 11, 11, 10, 00, 00 repeating; in_ready high once per 10 cycles.
- 10M, byte 0xF0 (en=1) -> TXD=0 for 50 cycles then F for 50; txc_d1 = txc_d2 = 1 for cycles 0..24, 0 for 25..49; next in_ready 100 cycles later.
- Gigabit frame with en=1, in_valid drops to 0 at a boundary -> next output byte idle (ctl=00), underrun=1 for exactly one cycle; no pulse if the previous byte had en=0.
- Speed switched 1000->100 mid-stream, then changed again mid-byte -> switch takes effect only at a boundary, phase restarts at 0, no truncated nibble or TXC glitch.
- rst asserted at 10M, phase 20 -> next cycle all outputs 0, in_ready=0; after release the speed is 1000 until speed is resampled.
